// File: rtl/rs232_pkt_ctrl.sv
// rtl/rs232_pkt_ctrl.sv - 8-byte RS232 register-access frame decoder with response sender
module rs232_pkt_ctrl #(
    parameter logic [15:0] DEV_ID   = 16'h3032,
    parameter int          TO_BYTES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  buad_setting,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        reg_wr_en,
    output logic [2:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    input  logic [15:0] reg_rd_data,
    output logic        pkt_ok,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, RECV, EXEC, SEND, WAIT_TX} state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [16:0] to_cnt_q;
    logic        cmd_wr_q;
    logic [15:0] data_q;
    logic [2:0]  tx_idx_q;
    logic        wait_first_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        reg_wr_en_q;
    logic [2:0]  reg_addr_q;
    logic [15:0] reg_wr_data_q;
    logic        pkt_ok_q;
    logic        frame_err_q;

    logic [12:0] baud_cnt;
    logic [16:0] to_limit;
    logic [7:0]  resp_byte;

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign pkt_ok      = pkt_ok_q;
    assign frame_err   = frame_err_q;

    // Clocks per bit at 50 MHz and the resulting inter-byte timeout
    always_comb begin
        case (buad_setting)
            2'd0:    baud_cnt = 13'd5208;
            2'd1:    baud_cnt = 13'd2604;
            default: baud_cnt = 13'd1302;
        endcase
        to_limit = 17'(32'(TO_BYTES) * 32'(baud_cnt));
    end

    // Response byte selected by the transmit index
    always_comb begin
        case (tx_idx_q)
            3'd0:    resp_byte = 8'h02;
            3'd1:    resp_byte = DEV_ID[15:8];
            3'd2:    resp_byte = DEV_ID[7:0];
            3'd3:    resp_byte = cmd_wr_q ? 8'h06 : 8'h00;
            3'd4:    resp_byte = {5'b0, reg_addr_q};
            3'd5:    resp_byte = data_q[15:8];
            3'd6:    resp_byte = data_q[7:0];
            default: resp_byte = 8'h03;
        endcase
    end

    // Frame receive, execute and response FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= 3'd0;
            to_cnt_q      <= 17'd0;
            cmd_wr_q      <= 1'b0;
            data_q        <= 16'h0000;
            tx_idx_q      <= 3'd0;
            wait_first_q  <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_addr_q    <= 3'd0;
            reg_wr_data_q <= 16'h0000;
            pkt_ok_q      <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            reg_wr_en_q <= 1'b0;
            pkt_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    to_cnt_q <= 17'd0;
                    if (rx_valid && rx_data == 8'h02) begin
                        idx_q   <= 3'd1;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    // A byte arriving on the expiry cycle wins over the timeout
                    if (rx_valid) begin
                        to_cnt_q <= 17'd0;
                        idx_q    <= idx_q + 3'd1;
                        case (idx_q)
                            3'd1: if (rx_data != DEV_ID[15:8]) begin
                                frame_err_q <= 1'b1;
                                state_q     <= IDLE;
                                idx_q       <= 3'd0;
                            end
                            3'd2: if (rx_data != DEV_ID[7:0]) begin
                                frame_err_q <= 1'b1;
                                state_q     <= IDLE;
                                idx_q       <= 3'd0;
                            end
                            3'd3: begin
                                if (rx_data == 8'h30) begin
                                    cmd_wr_q <= 1'b1;
                                end else if (rx_data == 8'h00) begin
                                    cmd_wr_q <= 1'b0;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= IDLE;
                                    idx_q       <= 3'd0;
                                end
                            end
                            3'd4: reg_addr_q     <= rx_data[2:0];
                            3'd5: data_q[15:8]   <= rx_data;
                            3'd6: data_q[7:0]    <= rx_data;
                            3'd7: begin
                                idx_q <= 3'd0;
                                if (rx_data == 8'h03) begin
                                    state_q     <= EXEC;
                                    pkt_ok_q    <= 1'b1;
                                    reg_wr_en_q <= cmd_wr_q;
                                    if (cmd_wr_q) begin
                                        reg_wr_data_q <= data_q;
                                    end
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end else if (to_cnt_q == 17'(to_limit - 17'd2)) begin
                        // Fires so frame_err lands exactly to_limit cycles after the last byte cycle
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                        idx_q       <= 3'd0;
                        to_cnt_q    <= 17'd0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 17'd1;
                    end
                end
                EXEC: begin
                    if (!cmd_wr_q) begin
                        data_q <= reg_rd_data;
                    end
                    tx_idx_q <= 3'd0;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start_q   <= 1'b1;
                        tx_data_q    <= resp_byte;
                        wait_first_q <= 1'b1;
                        state_q      <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // tx_busy only rises the cycle after tx_start, so skip one cycle
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (!tx_busy) begin
                        if (tx_idx_q == 3'd7) begin
                            state_q <= IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            state_q  <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_pkt_ctrl.sv
// tb/tb_rs232_pkt_ctrl.sv - scoreboard bench for rs232_pkt_ctrl
module tb_rs232_pkt_ctrl;

    localparam int TB_TO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  buad_setting;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        reg_wr_en;
    logic [2:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic [15:0] reg_rd_data;
    logic        pkt_ok;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  txq[$];
    logic [18:0] wrq[$];
    logic [15:0] regs [8];
    int cyc = 0, last_rx_cyc = 0, last_err_cyc = 0, last_pkt_cyc = 0;
    int pkt_cnt = 0, err_cnt = 0, tx_seen = 0, exp_pkt = 0, exp_err = 0;
    int busy_cnt = 0;

    rs232_pkt_ctrl #(.DEV_ID(16'h3032), .TO_BYTES(TB_TO)) dut (
        .clk(clk), .rst(rst), .buad_setting(buad_setting),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data), .pkt_ok(pkt_ok), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    assign reg_rd_data = regs[reg_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle numbering and rx timestamp
    always @(posedge clk) begin
        if (rx_valid) last_rx_cyc = cyc;
        cyc++;
    end

    // Transmitter model: busy for four cycles starting the cycle after tx_start
    always @(posedge clk) begin
        if (!rst) begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end else if (tx_start) begin
            busy_cnt <= 4;
            tx_busy  <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    // Output monitor and scoreboard pops
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (pkt_ok) begin pkt_cnt++; last_pkt_cyc = cyc; end
            if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
            if (tx_start) begin
                tx_seen++;
                if (txq.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'h1ff);
                else chk("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
            end
            if (reg_wr_en) begin
                if (wrq.size() == 0) chk("wr_unexpected", 32'({reg_addr, reg_wr_data}), 32'hfffff);
                else chk("wr_addr_data", 32'({reg_addr, reg_wr_data}), 32'(wrq.pop_front()));
                regs[reg_addr] = reg_wr_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] f, input int n);
        logic [63:0] v;
        v = f;
        for (int i = 0; i < n; i++) begin
            send_byte(v[63:56]);
            v = v << 8;
        end
    endtask

    task automatic expect_resp(input logic wr, input logic [2:0] a, input logic [15:0] d);
        txq.push_back(8'h02);
        txq.push_back(8'h30);
        txq.push_back(8'h32);
        txq.push_back(wr ? 8'h06 : 8'h00);
        txq.push_back({5'b0, a});
        txq.push_back(d[15:8]);
        txq.push_back(d[7:0]);
        txq.push_back(8'h03);
        if (wr) wrq.push_back({a, d});
        exp_pkt++;
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 3000 && txq.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(txq.size()), 32'd0);
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_reset_outs();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
        chk("rst_pkt_ok", 32'(pkt_ok), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    task automatic expect_err(input string tag);
        exp_err++;
        chk(tag, 32'(last_err_cyc - last_rx_cyc), 32'd1);
    endtask

    task automatic wait_timeout(input string tag, input int limit);
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < limit + 100 && err_cnt == e0; i++) @(negedge clk);
        chk({tag, "_fired"}, 32'(err_cnt), 32'(e0 + 1));
        chk({tag, "_time"}, 32'(last_err_cyc - last_rx_cyc), 32'(limit));
        exp_err++;
    endtask

    initial begin
        int base;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[0]      = 16'h1234;
        rst          = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        buad_setting = 2'd2;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Write frame at 38400
        expect_resp(1'b1, 3'd3, 16'h01C8);
        send_frame(64'h02_30_32_30_03_01_C8_03, 8);
        chk("pkt_latency", 32'(last_pkt_cyc - last_rx_cyc), 32'd1);
        wait_resp("write_resp");

        // Read frame from address 0
        expect_resp(1'b0, 3'd0, 16'h1234);
        send_frame(64'h02_30_32_00_00_00_64_03, 8);
        wait_resp("read_resp");

        // Wrong device address low byte
        send_frame(64'h02_30_33_00_00_00_00_00, 3);
        expect_err("bad_b2_latency");
        repeat (20) @(negedge clk);
        chk("bad_b2_no_tx", 32'(txq.size()), 32'd0);

        // Next valid frame still accepted
        expect_resp(1'b1, 3'd5, 16'hA55A);
        send_frame(64'h02_30_32_30_05_A5_5A_03, 8);
        wait_resp("after_err_resp");

        // Garbage before STX then a read-back
        send_byte(8'h55);
        send_byte(8'hAA);
        expect_resp(1'b0, 3'd5, 16'hA55A);
        send_frame(64'h02_30_32_00_05_00_00_03, 8);
        wait_resp("garbage_resp");

        // STX inside a frame is data, fails the B1 check
        send_frame(64'h02_02_00_00_00_00_00_00, 2);
        expect_err("stx_in_recv");
        // Illegal command byte
        send_frame(64'h02_30_32_31_00_00_00_00, 4);
        expect_err("bad_cmd");
        // Bad ETX, no write must appear
        send_frame(64'h02_30_32_30_01_00_11_04, 8);
        expect_err("bad_etx");
        repeat (20) @(negedge clk);

        // Inter-byte timeouts at 38400 and 9600
        send_frame(64'h02_30_32_30_00_00_00_00, 4);
        wait_timeout("to_38400", TB_TO * 1302);
        buad_setting = 2'd0;
        send_frame(64'h02_30_32_30_01_00_00_00, 5);
        wait_timeout("to_9600", TB_TO * 5208);
        buad_setting = 2'd2;

        // Bytes received during the response are ignored
        expect_resp(1'b1, 3'd2, 16'h0F0F);
        send_frame(64'h02_30_32_30_02_0F_0F_03, 8);
        base = tx_seen;
        for (int i = 0; i < 200 && tx_seen == base; i++) @(negedge clk);
        send_frame(64'h02_30_32_00_00_00_00_00, 3);
        wait_resp("halfduplex_resp");

        // Reset during response byte 3
        expect_resp(1'b1, 3'd6, 16'hBEEF);
        send_frame(64'h02_30_32_30_06_BE_EF_03, 8);
        base = tx_seen;
        for (int i = 0; i < 500 && tx_seen < base + 4; i++) @(negedge clk);
        chk("reached_byte3", 32'(tx_seen - base), 32'd4);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        txq.delete();
        exp_pkt = exp_pkt;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        base = tx_seen;
        repeat (200) @(negedge clk);
        chk("no_tx_after_reset", 32'(tx_seen - base), 32'd0);

        // Fresh frame after reset reads back the value written before it
        expect_resp(1'b0, 3'd6, 16'hBEEF);
        send_frame(64'h02_30_32_00_06_00_00_03, 8);
        wait_resp("post_reset_resp");

        chk("pkt_total", 32'(pkt_cnt), 32'(exp_pkt));
        chk("err_total", 32'(err_cnt), 32'(exp_err));
        chk("writes_left", 32'(wrq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
